sat_addsub_pipe: RTL and testbench
==================================

SAT_ADDSUB_PIPE -- requirements
Module: sat_addsub_pipe

Interface
REQ-001 SHALL have parameter W, default 10: signed two's-complement operand and result width per lane.
REQ-002 SHALL have parameter LANES, default 4: number of independent lanes processed per transaction.
REQ-003 SHALL have parameter CNT_W, default 16: width of the saturation-event counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operands and mode are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts a transaction this cycle.
REQ-008 SHALL have port mode, input, 1, 0 = subtract (a-b), 1 = add (a+b); applies to all lanes of the transaction.
REQ-009 SHALL have port a, input, LANES*W, lane k operand at bits [k*W +: W].
REQ-010 SHALL have port b, input, LANES*W, lane k operand at bits [k*W +: W].
REQ-011 SHALL have port out_valid, output, 1, result is valid this cycle.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result this cycle.
REQ-013 SHALL have port res, output, LANES*W, lane k saturated result at bits [k*W +: W].
REQ-014 SHALL have port sat, output, LANES, bit k set when lane k result was clamped.
REQ-015 SHALL have port clr_cnt, input, 1, synchronous clear of sat_cnt.
REQ-016 SHALL have port sat_cnt, output, CNT_W, count of delivered transactions with any sat bit set.

Function
REQ-017 Each lane SHALL compute the exact result in W+1 bits, sign-extending both operands; the subtract path SHALL compute x + ~y + 1.
REQ-018 Each lane SHALL clamp a result above 2^(W-1)-1 to 2^(W-1)-1 and a result below -2^(W-1) to -2^(W-1), and set its sat bit; otherwise it SHALL pass the low W bits and clear its sat bit.
REQ-019 The block SHALL be a two-stage pipeline: stage 1 registers a, b and mode on acceptance; stage 2 registers res and sat; latency is 2 cycles from acceptance to out_valid with out_ready held high.
REQ-020 A transfer SHALL occur on a cycle where valid and ready are both high, on each side independently.
REQ-021 Stage 2 SHALL load when stage 1 is valid and stage 2 is empty or out_ready is high; in_ready SHALL be high when stage 1 is empty or stage 1 loads stage 2 in that cycle.
REQ-022 Sustained throughput SHALL be one transaction per cycle with out_ready high; no transaction SHALL be dropped, duplicated or reordered under any backpressure pattern.
REQ-023 res, sat and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 sat_cnt SHALL increment by 1 on each output transfer with any sat bit set, and SHALL stick at all-ones instead of wrapping.
REQ-025 When clr_cnt and a counting transfer occur in the same cycle, clr_cnt SHALL win and sat_cnt SHALL be 0 next cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear stage-1 and stage-2 valid, out_valid, res, sat and sat_cnt to 0.
REQ-027 In-flight transactions SHALL be discarded by reset, including a reset asserted mid-stream.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the mode encodings MODE_SUB=0 and MODE_ADD=1 and the default W, LANES and CNT_W values.
REQ-030 Per-lane arithmetic SHALL be a combinational sub-module sat_addsub_lane (parameter W; inputs a, b, mode; outputs res, sat), instantiated LANES times by generate.

Verification
REQ-031 W=10, mode=0, lane0 a=511 b=-1 -> res=511, sat[0]=1; lane1 a=-512 b=1 -> res=-512, sat[1]=1; lane2 a=-512 b=-512 -> res=0, sat[2]=0.
REQ-032 W=10, mode=1, lane0 300+300 -> res=511, sat=1; lane1 511+(-512) -> res=-1, sat=0; lane2 -300+(-300) -> res=-512, sat=1.
REQ-033 Send 3 back-to-back transactions with out_ready=0 for 4 cycles: in_ready SHALL drop after 2 are accepted; after out_ready=1, all 3 SHALL emerge in order with unchanged data.
REQ-034 CNT_W=2, send 5 saturating transactions -> sat_cnt = 1, 2, 3, 3, 3; assert clr_cnt on the 6th saturating transfer -> sat_cnt = 0.
REQ-035 Assert rst_n low while both stages are valid -> out_valid=0 and sat_cnt=0 immediately; no stale result SHALL appear after release.
REQ-036 Random valid/ready toggling over 10k transactions, checked against a scoreboard -> zero mismatches and no loss.

Source files
------------

// File: rtl/sat_addsub_pipe_pkg.sv
// Shared encodings and default sizing for the saturating add/sub pipeline.
package sat_addsub_pipe_pkg;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  localparam int unsigned DEF_W     = 10;
  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_CNT_W = 16;

endpackage : sat_addsub_pipe_pkg

// File: rtl/sat_addsub_lane.sv
// One lane of signed saturating add/subtract, purely combinational.
module sat_addsub_lane
  import sat_addsub_pipe_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] res,
  output logic         sat
);

  localparam int unsigned XW = W + 1;

  logic [W:0] xe;
  logic [W:0] ye;
  logic [W:0] sum;

  // Exact W+1 bit result, then clamp when the top two bits disagree.
  always_comb begin
    xe = {a[W-1], a};
    ye = {b[W-1], b};
    if (mode == MODE_ADD) begin
      sum = xe + ye;
    end else begin
      sum = xe + ~ye + XW'(1);
    end
    sat = sum[W] ^ sum[W-1];
    if (!sat) begin
      res = sum[W-1:0];
    end else if (sum[W]) begin
      res = {1'b1, {(W-1){1'b0}}};
    end else begin
      res = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule : sat_addsub_lane

// File: rtl/sat_addsub_pipe.sv
// Two-stage, multi-lane saturating add/sub with valid/ready on both sides
// and a sticky count of delivered transactions that saturated.
module sat_addsub_pipe
  import sat_addsub_pipe_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   res,
  output logic [LANES-1:0]     sat,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int unsigned DW = LANES * W;

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    res_q, res_d;
  logic [LANES-1:0] sat_q, sat_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic [DW-1:0]    lane_res;
  logic [LANES-1:0] lane_sat;
  logic             s2_load;
  logic             in_xfer;
  logic             out_xfer;

  // Per-lane arithmetic on the stage-1 operands.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_addsub_lane #(.W(W)) u_lane (
      .a    (a_q[k*W +: W]),
      .b    (b_q[k*W +: W]),
      .mode (mode_q),
      .res  (lane_res[k*W +: W]),
      .sat  (lane_sat[k])
    );
  end

  // Handshake decisions: stage 2 drains or is empty, stage 1 then frees up.
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;
  end

  // Next-state for both pipeline stages and the saturation counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    sat_d       = sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      mode_d     = mode;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      res_d       = lane_res;
      sat_d       = lane_sat;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    // Clear beats a simultaneous count; the count sticks at all-ones.
    if (clr_cnt) begin
      sat_cnt_d = '0;
    end else if (out_xfer && (|sat_q) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_SUB;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sat_q       <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      sat_q       <= sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign sat       = sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule : sat_addsub_pipe

// File: tb/tb_sat_addsub_pipe.sv
// Directed and randomized bench for sat_addsub_pipe (W=10, LANES=4, CNT_W=2).
module tb_sat_addsub_pipe;

  localparam int W     = 10;
  localparam int LANES = 4;
  localparam int CNT_W = 2;
  localparam int DW    = LANES * W;
  localparam int MAXV  = 511;
  localparam int MINV  = -512;
  localparam int NRAND = 10000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [DW-1:0]    a;
  logic [DW-1:0]    b;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    res;
  logic [LANES-1:0] sat;
  logic             clr_cnt;
  logic [CNT_W-1:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  sat_addsub_pipe #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .sat       (sat),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
  endfunction

  // Reference: integer arithmetic with explicit clamping.
  function automatic logic [DW+LANES-1:0] model(input logic m, input logic [DW-1:0] av,
                                                input logic [DW-1:0] bv);
    logic [DW-1:0]    r;
    logic [LANES-1:0] s;
    logic [W-1:0]     ta;
    logic [W-1:0]     tb;
    int               x;
    int               y;
    int               z;
    r = '0;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      ta = av[k*W +: W];
      tb = bv[k*W +: W];
      x  = int'($signed(ta));
      y  = int'($signed(tb));
      z  = m ? (x + y) : (x - y);
      if (z > MAXV) begin
        z    = MAXV;
        s[k] = 1'b1;
      end else if (z < MINV) begin
        z    = MINV;
        s[k] = 1'b1;
      end
      r[k*W +: W] = 10'(z);
    end
    return {s, r};
  endfunction

  // One transaction through an idle pipe with out_ready high.
  task automatic single(input string tag, input logic m, input logic [DW-1:0] av,
                        input logic [DW-1:0] bv, input logic [DW-1:0] er,
                        input logic [LANES-1:0] es, input logic clr);
    in_valid = 1'b1;
    mode     = m;
    a        = av;
    b        = bv;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_res"}, 64'(res), 64'(er));
    check({tag, "_sat"}, 64'(sat), 64'(es));
    clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
    check({tag, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  logic [DW+LANES-1:0] e;
  logic [DW+LANES-1:0] q[$];
  logic [DW-1:0]       pres;
  logic [LANES-1:0]    psat;
  logic                hold;
  logic                acc;
  int                  sent;
  int                  recv;
  int                  cyc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    mode      = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_res", 64'(res), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    #10;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    tick();

    // Subtract boundaries
    single("sub", 1'b0, pack4(511, -512, -512, 5), pack4(-1, 1, -512, 3),
           pack4(511, -512, 0, 2), 4'b0011, 1'b0);
    check("sub_cnt", 64'(sat_cnt), 64'(1));

    // Add boundaries
    single("add", 1'b1, pack4(300, 511, -300, 100), pack4(300, -512, -300, -50),
           pack4(511, -1, -512, 50), 4'b0101, 1'b0);
    check("add_cnt", 64'(sat_cnt), 64'(2));

    // Backpressure: three back-to-back with out_ready low for four edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode = 1'b1; a = pack4(1, 2, 3, 4); b = pack4(10, 20, 30, 40);
    #1;
    check("bp_rdy0", 64'(in_ready), 64'(1));
    tick();
    mode = 1'b0; a = pack4(100, -100, 0, 7); b = pack4(1, 1, 1, 1);
    #1;
    check("bp_rdy1", 64'(in_ready), 64'(1));
    tick();
    mode = 1'b1; a = pack4(511, 0, 0, 0); b = pack4(1, 0, 0, 0);
    #1;
    check("bp_rdy2", 64'(in_ready), 64'(0));
    check("bp_ov", 64'(out_valid), 64'(1));
    check("bp_res0", 64'(res), 64'(pack4(11, 22, 33, 44)));
    tick();
    check("bp_rdy3", 64'(in_ready), 64'(0));
    check("bp_hold_res", 64'(res), 64'(pack4(11, 22, 33, 44)));
    check("bp_hold_ov", 64'(out_valid), 64'(1));
    tick();
    out_ready = 1'b1;
    #1;
    check("bp_rdy4", 64'(in_ready), 64'(1));
    check("bp_out0_res", 64'(res), 64'(pack4(11, 22, 33, 44)));
    check("bp_out0_sat", 64'(sat), 64'(0));
    tick();
    in_valid = 1'b0;
    check("bp_out1_ov", 64'(out_valid), 64'(1));
    check("bp_out1_res", 64'(res), 64'(pack4(99, -101, -1, 6)));
    check("bp_out1_sat", 64'(sat), 64'(0));
    tick();
    check("bp_out2_ov", 64'(out_valid), 64'(1));
    check("bp_out2_res", 64'(res), 64'(pack4(511, 0, 0, 0)));
    check("bp_out2_sat", 64'(sat), 64'(4'b0001));
    tick();
    check("bp_empty", 64'(out_valid), 64'(0));
    check("bp_cnt_full", 64'(sat_cnt), 64'(3));

    // Counter clear, then sticky count and clear-wins
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_cnt", 64'(sat_cnt), 64'(0));
    single("cnt1", 1'b1, pack4(511, 0, 0, 0), pack4(1, 0, 0, 0), pack4(511, 0, 0, 0), 4'b0001, 1'b0);
    check("cnt1_val", 64'(sat_cnt), 64'(1));
    single("cnt2", 1'b0, pack4(0, -512, 0, 0), pack4(0, 1, 0, 0), pack4(0, -512, 0, 0), 4'b0010, 1'b0);
    check("cnt2_val", 64'(sat_cnt), 64'(2));
    single("cnt3", 1'b1, pack4(0, 0, 400, 0), pack4(0, 0, 400, 0), pack4(0, 0, 511, 0), 4'b0100, 1'b0);
    check("cnt3_val", 64'(sat_cnt), 64'(3));
    single("cnt4", 1'b1, pack4(0, 0, 0, -400), pack4(0, 0, 0, -400), pack4(0, 0, 0, -512), 4'b1000, 1'b0);
    check("cnt4_val", 64'(sat_cnt), 64'(3));
    single("cnt5", 1'b0, pack4(511, 0, 0, 0), pack4(-511, 0, 0, 0), pack4(511, 0, 0, 0), 4'b0001, 1'b0);
    check("cnt5_val", 64'(sat_cnt), 64'(3));
    single("cnt6", 1'b1, pack4(511, 0, 0, 0), pack4(511, 0, 0, 0), pack4(511, 0, 0, 0), 4'b0001, 1'b1);
    check("cnt6_clr_wins", 64'(sat_cnt), 64'(0));

    // Reset with both stages full
    single("pre_rst", 1'b1, pack4(511, 0, 0, 0), pack4(1, 0, 0, 0), pack4(511, 0, 0, 0), 4'b0001, 1'b0);
    check("pre_rst_cnt", 64'(sat_cnt), 64'(1));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode = 1'b1; a = pack4(500, 0, 0, 0); b = pack4(500, 0, 0, 0);
    tick();
    a = pack4(-500, 0, 0, 0); b = pack4(-500, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    check("full_ov", 64'(out_valid), 64'(1));
    check("full_rdy", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'(0));
    check("mid_rst_cnt", 64'(sat_cnt), 64'(0));
    check("mid_rst_res", 64'(res), 64'(0));
    check("mid_rst_sat", 64'(sat), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_rdy", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end

    // Random valid/ready traffic against a scoreboard
    sent = 0;
    recv = 0;
    cyc  = 0;
    hold = 1'b0;
    acc  = 1'b0;
    pres = '0;
    psat = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (recv < NRAND && cyc < 60000) begin
      tick();
      cyc++;
      if (hold) begin
        check("rnd_hold_ov", 64'(out_valid), 64'(1));
        check("rnd_hold_res", 64'(res), 64'(pres));
        check("rnd_hold_sat", 64'(sat), 64'(psat));
      end
      if (!in_valid || acc) begin
        if (sent < NRAND && $urandom_range(0, 9) < 8) begin
          in_valid = 1'b1;
          mode     = 1'($urandom());
          a        = 40'({$urandom(), $urandom()});
          b        = 40'({$urandom(), $urandom()});
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(mode, a, b));
        sent++;
      end
      if (out_valid && out_ready) begin
        check("rnd_sb_nonempty", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_res", 64'(res), 64'(e[DW-1:0]));
          check("rnd_sat", 64'(sat), 64'(e[DW +: LANES]));
        end
        recv++;
      end
      hold = out_valid && !out_ready;
      pres = res;
      psat = sat;
    end
    check("rnd_received", 64'(recv), 64'(NRAND));
    check("rnd_sent", 64'(sent), 64'(NRAND));
    check("rnd_left", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sat_addsub_pipe
